// File: rtl/dma_copy_engine.sv
// ============================================================================
// dma_copy_engine : block COPY/FILL initiator for the 8-bit data memory port
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_copy_engine #(
   parameter int AW    = 8,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   input  logic [7:0]    fill_val,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [7:0]    mem_dat_in,
   input  logic [7:0]    mem_dat_out
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_rd   = 2'd1;
   localparam logic [1:0] c_wr   = 2'd2;
   localparam logic [1:0] c_done = 2'd3;

   // DEPTH is a power of two, so wrapping is a mask on the pointer
   localparam logic [AW-1:0] c_addr_mask = AW'(DEPTH - 1);

   logic [1:0]    state;
   logic [AW-1:0] src_p;
   logic [AW-1:0] dst_p;
   logic [AW-1:0] cnt;
   logic          mode_r;
   logic [7:0]    fill_r;
   logic [7:0]    buf_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= c_idle;
         src_p  <= '0;
         dst_p  <= '0;
         cnt    <= '0;
         mode_r <= 1'b0;
         fill_r <= '0;
         buf_r  <= '0;
      end else begin
         case (state)
            c_idle: begin
               if (start) begin
                  src_p  <= src & c_addr_mask;
                  dst_p  <= dst & c_addr_mask;
                  cnt    <= len;
                  mode_r <= mode;
                  fill_r <= fill_val;
                  if (len == '0)
                     state <= c_done;
                  else if (mode)
                     state <= c_wr;
                  else
                     state <= c_rd;
               end
            end
            c_rd: begin
               buf_r <= mem_dat_out;
               state <= c_wr;
            end
            c_wr: begin
               src_p <= (src_p + AW'(1)) & c_addr_mask;
               dst_p <= (dst_p + AW'(1)) & c_addr_mask;
               cnt   <= cnt - AW'(1);
               if (cnt == AW'(1))
                  state <= c_done;
               else if (mode_r)
                  state <= c_wr;
               else
                  state <= c_rd;
            end
            default: state <= c_idle;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset drops them at once
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      mem_addr   = '0;
      mem_wr_en  = 1'b0;
      mem_dat_in = '0;
      case (state)
         c_rd: begin
            busy     = 1'b1;
            mem_addr = src_p;
         end
         c_wr: begin
            busy       = 1'b1;
            mem_addr   = dst_p;
            mem_wr_en  = 1'b1;
            mem_dat_in = mode_r ? fill_r : buf_r;
         end
         c_done: done = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
// ============================================================================
// tb_dma_copy_engine : directed vector bench with a 64-byte memory model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_copy_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic [7:0] src;
   logic [7:0] dst;
   logic [7:0] len;
   logic [7:0] fill_val;
   logic       busy;
   logic       done;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_dat_in;
   logic [7:0] mem_dat_out;

   logic [7:0]  mem [64];
   logic        init_req;
   logic [5:0]  pre_addr;
   logic [23:0] pre_v;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        mode;
      logic [7:0]  src;
      logic [7:0]  dst;
      logic [7:0]  len;
      logic [7:0]  fill;
      logic [5:0]  pre_addr;
      logic [23:0] pre_v;
      int          exp_busy;
      int          exp_wr;
      logic        repulse;
      logic [23:0] ca;
      logic [31:0] cv;
   } vec_t;

   vec_t vecs[8];

   dma_copy_engine #(.AW(8), .DEPTH(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .src         (src),
      .dst         (dst),
      .len         (len),
      .fill_val    (fill_val),
      .busy        (busy),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_dat_in  (mem_dat_in),
      .mem_dat_out (mem_dat_out)
   );

   always #5 clk = ~clk;

   // Memory model: background pattern mem[i] = 0x40 + i, then three preload bytes
   assign mem_dat_out = mem[mem_addr[5:0]];

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i) + 8'h40;
         for (int k = 0; k < 3; k++) mem[6'(pre_addr + 6'(k))] <= pre_v[k*8 +: 8];
      end else if (mem_wr_en) begin
         mem[mem_addr[5:0]] <= mem_dat_in;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [7:0] l, input logic [7:0] f,
                               input logic [5:0] pa, input logic [23:0] pv,
                               input int eb, input int ew, input logic rp,
                               input logic [23:0] ca, input logic [31:0] cv);
      vec_t v;
      v.mode = m; v.src = s; v.dst = d; v.len = l; v.fill = f;
      v.pre_addr = pa; v.pre_v = pv; v.exp_busy = eb; v.exp_wr = ew;
      v.repulse = rp; v.ca = ca; v.cv = cv;
      return v;
   endfunction

   task automatic load_mem(input logic [5:0] pa, input logic [23:0] pv);
      @(negedge clk);
      pre_addr = pa;
      pre_v    = pv;
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  busy_n = 0;
      int  wr_n   = 0;
      logic got_done = 1'b0;
      logic hi_bad   = 1'b0;
      load_mem(v.pre_addr, v.pre_v);
      mode = v.mode; src = v.src; dst = v.dst; len = v.len; fill_val = v.fill;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (mem_addr[7:6] != 2'b00) hi_bad = 1'b1;
         if (busy) busy_n++;
         if (mem_wr_en) wr_n++;
         if (done) got_done = 1'b1;
         start = (v.repulse && busy && busy_n == 2);
      end
      start = 1'b0;
      chk($sformatf("v%0d done_seen", idx), 32'(got_done), 32'd1);
      chk($sformatf("v%0d busy_cycles", idx), 32'(busy_n), 32'(v.exp_busy));
      chk($sformatf("v%0d write_cycles", idx), 32'(wr_n), 32'(v.exp_wr));
      chk($sformatf("v%0d addr_high_bits", idx), 32'(hi_bad), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d idle_after_done", idx), {30'd0, busy, done}, 32'd0);
      for (int k = 0; k < 4; k++)
         chk($sformatf("v%0d mem[%0d]", idx, v.ca[k*6 +: 6]),
             32'(mem[v.ca[k*6 +: 6]]), 32'(v.cv[k*8 +: 8]));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
      fill_val = '0; init_req = 1'b0; pre_addr = '0; pre_v = '0;

      // Check addresses packed {c3,c2,c1,c0}, values {v3,v2,v1,v0}; preload {p2,p1,p0}
      vecs[0] = mk(0, 8'd4,    8'd20,   8'd3,  8'h00, 6'd4,  24'hC3B2A1, 6, 3, 0,
                   {6'd23, 6'd22, 6'd21, 6'd20}, 32'h57C3B2A1);
      vecs[1] = mk(1, 8'd0,    8'd62,   8'd4,  8'h5A, 6'd40, 24'h332211, 4, 4, 0,
                   {6'd1, 6'd0, 6'd63, 6'd62},   32'h5A5A5A5A);
      vecs[2] = mk(0, 8'd1,    8'd2,    8'd0,  8'h00, 6'd40, 24'h332211, 0, 0, 0,
                   {6'd0, 6'd1, 6'd3, 6'd2},     32'h40414342);
      vecs[3] = mk(1, 8'd0,    8'd5,    8'd0,  8'hFF, 6'd40, 24'h332211, 0, 0, 0,
                   {6'd7, 6'd4, 6'd6, 6'd5},     32'h47444645);
      vecs[4] = mk(0, 8'd10,   8'd11,   8'd3,  8'h00, 6'd10, 24'h020177, 6, 3, 1,
                   {6'd14, 6'd13, 6'd12, 6'd11}, 32'h4E777777);
      vecs[5] = mk(0, 8'h44,   8'hC8,   8'd2,  8'h00, 6'd4,  24'h9C9B9A, 4, 2, 0,
                   {6'd4, 6'd10, 6'd9, 6'd8},    32'h9A4A9B9A);
      vecs[6] = mk(1, 8'd0,    8'd0,    8'd66, 8'hE7, 6'd40, 24'h332211, 66, 66, 0,
                   {6'd63, 6'd2, 6'd1, 6'd0},    32'hE7E7E7E7);
      vecs[7] = mk(0, 8'd30,   8'd30,   8'd2,  8'h00, 6'd48, 24'h332211, 4, 2, 0,
                   {6'd29, 6'd32, 6'd31, 6'd30}, 32'h5D605F5E);

      #1;
      chk("reset busy",       32'(busy),       32'd0);
      chk("reset done",       32'(done),       32'd0);
      chk("reset mem_wr_en",  32'(mem_wr_en),  32'd0);
      chk("reset mem_addr",   32'(mem_addr),   32'd0);
      chk("reset mem_dat_in", 32'(mem_dat_in), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset during the write of byte 2 of a 5-byte COPY 0 -> 32
      load_mem(6'd0, 24'hD3D2D1);
      mode = 1'b0; src = 8'd0; dst = 8'd32; len = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort pre wr_en", 32'(mem_wr_en), 32'd1);
      chk("abort pre addr",  32'(mem_addr),  32'd33);
      reset = 1'b1;
      #1;
      chk("abort busy",  32'(busy),      32'd0);
      chk("abort done",  32'(done),      32'd0);
      chk("abort wr_en", 32'(mem_wr_en), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort mem[32]", 32'(mem[32]), 32'hD1);
      chk("abort mem[33]", 32'(mem[33]), 32'h61);
      run_vec(mk(0, 8'd0, 8'd32, 8'd5, 8'h00, 6'd0, 24'hD3D2D1, 10, 5, 0,
                 {6'd37, 6'd36, 6'd34, 6'd32}, 32'h6544D3D1), 8);

      // Start held high: the second transfer is taken in IDLE, never in DONE
      load_mem(6'd48, 24'h332211);
      mode = 1'b1; dst = 8'd40; len = 8'd2; fill_val = 8'h3C; start = 1'b1;
      repeat (3) @(negedge clk);
      chk("b2b first done", 32'(done), 32'd1);
      @(negedge clk);
      chk("b2b idle gap", {30'd0, busy, done}, 32'd0);
      @(negedge clk);
      chk("b2b restart busy", 32'(busy), 32'd1);
      chk("b2b restart addr", 32'(mem_addr), 32'd40);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("b2b second done", 32'(done), 32'd1);
      chk("b2b mem[41]", 32'(mem[41]), 32'h3C);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
